video_mode_ctrl: RTL and testbench

VIDEO_MODE_CTRL -- requirements
Module: video_mode_ctrl

---
 rtl/video_mode_ctrl_if.sv | 21 ++
 rtl/video_mode_ctrl.sv | 152 +++++++++++++++
 tb/tb_video_mode_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_mode_ctrl_if.sv
// Mode-change request channel: the requester (master) holds cfg_req with the
// wanted mode until the controller (slave) pulses cfg_ack.
interface video_mode_ctrl_if;
   logic       cfg_req;
   logic [1:0] cfg_scanlines;
   logic       cfg_sd_disable;
   logic       cfg_hq2x;
   logic       cfg_ypbpr;
   logic       cfg_ypbpr_full;
   logic       cfg_ack;

   modport master (
      output cfg_req, cfg_scanlines, cfg_sd_disable, cfg_hq2x, cfg_ypbpr, cfg_ypbpr_full,
      input  cfg_ack
   );

   modport slave (
      input  cfg_req, cfg_scanlines, cfg_sd_disable, cfg_hq2x, cfg_ypbpr, cfg_ypbpr_full,
      output cfg_ack
   );
endinterface

// File: rtl/video_mode_ctrl.sv
// Applies video mode changes on frame boundaries, muting the mixer around
// switches that would otherwise show a corrupted frame.
module video_mode_ctrl #(
   parameter int          MUTE_FRAMES   = 1,
   parameter int          SETTLE_FRAMES = 2,
   parameter logic [23:0] TIMEOUT       = 24'd4_000_000
) (
   input  logic             clk_sys,
   input  logic             reset_n,
   input  logic             VSync,
   video_mode_ctrl_if.slave cfg,
   output logic [1:0]       scanlines,
   output logic             scandoubler_disable,
   output logic             hq2x,
   output logic             ypbpr,
   output logic             ypbpr_full,
   output logic             mute,
   output logic             busy
);

   typedef enum logic [2:0] {IDLE, FAST, PRE_MUTE, APPLY, SETTLE} state_t;

   typedef struct packed {
      logic [1:0] scanlines;
      logic       sd_disable;
      logic       hq2x;
      logic       ypbpr;
      logic       ypbpr_full;
   } mode_t;

   // Fields the mixer can change between frames without a visible glitch.
   localparam mode_t FAST_MASK = mode_t'(6'b11_0001);

   state_t      state_q, state_d;
   mode_t       shadow_q, shadow_d;
   mode_t       mode_q, mode_d;
   logic        mute_q, mute_d;
   logic        busy_q, busy_d;
   logic        cfg_ack_q, cfg_ack_d;
   logic [7:0]  frame_q, frame_d;
   logic [23:0] tmo_q, tmo_d;
   logic [1:0]  rst_sync_q, rst_sync_d;
   logic [2:0]  vs_sync_q, vs_sync_d;

   mode_t       req_mode;
   logic        run;
   logic        vs_rise;
   logic        frame_ev;
   logic [7:0]  frame_inc;

   assign req_mode  = '{scanlines:  cfg.cfg_scanlines,  sd_disable: cfg.cfg_sd_disable,
                        hq2x:       cfg.cfg_hq2x,       ypbpr:      cfg.cfg_ypbpr,
                        ypbpr_full: cfg.cfg_ypbpr_full};
   assign run       = rst_sync_q[1];
   assign vs_rise   = vs_sync_q[1] & ~vs_sync_q[2];
   // A stalled timeout stands in for the VSync edge that never came.
   assign frame_ev  = vs_rise | (tmo_q == TIMEOUT);
   assign frame_inc = (frame_q == 8'hFF) ? frame_q : frame_q + {7'd0, frame_ev};

   always_comb begin
      // NOTE: every _d gets a default first so no path through the case infers a latch.
      state_d    = state_q;
      shadow_d   = shadow_q;
      mode_d     = mode_q;
      cfg_ack_d  = 1'b0;
      frame_d    = frame_q;
      tmo_d      = tmo_q;
      rst_sync_d = {rst_sync_q[0], 1'b1};
      vs_sync_d  = {vs_sync_q[1:0], VSync};

      if (run) begin
         case (state_q)
            IDLE: begin
               // cfg_ack_q blocks a second capture of a request already acknowledged.
               if (cfg.cfg_req && !cfg_ack_q) begin
                  cfg_ack_d = 1'b1;
                  shadow_d  = req_mode;
                  if (req_mode == mode_q)
                     state_d = IDLE;
                  else if (((req_mode ^ mode_q) & ~FAST_MASK) == '0)
                     state_d = FAST;
                  else
                     state_d = PRE_MUTE;
               end
            end
            FAST: begin
               if (frame_ev) begin
                  mode_d  = shadow_q;
                  state_d = IDLE;
               end
            end
            PRE_MUTE: begin
               if (int'({24'd0, frame_inc}) >= MUTE_FRAMES) state_d = APPLY;
               else                                          frame_d = frame_inc;
            end
            APPLY: begin
               mode_d  = shadow_q;
               state_d = SETTLE;
            end
            SETTLE: begin
               if (int'({24'd0, frame_inc}) >= SETTLE_FRAMES) state_d = IDLE;
               else                                            frame_d = frame_inc;
            end
            default: state_d = IDLE;
         endcase

         if (state_d != state_q)                              frame_d = '0;
         if (state_d != state_q || frame_ev)                  tmo_d   = '0;
         else if (state_q inside {FAST, PRE_MUTE, SETTLE})    tmo_d   = tmo_q + 24'd1;
      end

      mute_d = state_d inside {PRE_MUTE, APPLY, SETTLE};
      busy_d = (state_d != IDLE);
   end

   // NOTE: non-blocking only here, so every flop samples the pre-edge value of every other flop.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         shadow_q   <= '0;
         mode_q     <= '0;
         mute_q     <= 1'b0;
         busy_q     <= 1'b0;
         cfg_ack_q  <= 1'b0;
         frame_q    <= '0;
         tmo_q      <= '0;
         rst_sync_q <= '0;
         vs_sync_q  <= '0;
      end else begin
         state_q    <= state_d;
         shadow_q   <= shadow_d;
         mode_q     <= mode_d;
         mute_q     <= mute_d;
         busy_q     <= busy_d;
         cfg_ack_q  <= cfg_ack_d;
         frame_q    <= frame_d;
         tmo_q      <= tmo_d;
         rst_sync_q <= rst_sync_d;
         vs_sync_q  <= vs_sync_d;
      end
   end

   assign cfg.cfg_ack         = cfg_ack_q;
   assign scanlines           = mode_q.scanlines;
   assign scandoubler_disable = mode_q.sd_disable;
   assign hq2x                = mode_q.hq2x;
   assign ypbpr               = mode_q.ypbpr;
   assign ypbpr_full          = mode_q.ypbpr_full;
   assign mute                = mute_q;
   assign busy                = busy_q;

endmodule

// File: tb/tb_video_mode_ctrl.sv
// Self-checking bench for video_mode_ctrl: directed scenarios with literal
// expectations plus randomized requests checked every cycle against a frame-level model.
module tb_video_mode_ctrl;

   localparam int         MUTE_TB    = 1;
   localparam int         SETTLE_TB  = 2;
   localparam int         TIMEOUT_TB = 100;
   localparam logic [5:0] FAST_BITS  = 6'b11_0001;

   logic       clk_sys = 1'b0;
   logic       reset_n = 1'b1;
   logic       vsync   = 1'b0;
   logic [1:0] scanlines;
   logic       scandoubler_disable, hq2x, ypbpr, ypbpr_full, mute, busy;
   logic [5:0] dut_mode;

   int tests = 0;
   int fails = 0;

   bit vs_auto = 1'b0;
   bit vs_rand = 1'b0;
   int vs_period = 20;

   video_mode_ctrl_if cfg_if ();

   video_mode_ctrl #(
      .MUTE_FRAMES   (MUTE_TB),
      .SETTLE_FRAMES (SETTLE_TB),
      .TIMEOUT       (24'(TIMEOUT_TB))
   ) dut (
      .clk_sys             (clk_sys),
      .reset_n             (reset_n),
      .VSync               (vsync),
      .cfg                 (cfg_if),
      .scanlines           (scanlines),
      .scandoubler_disable (scandoubler_disable),
      .hq2x                (hq2x),
      .ypbpr               (ypbpr),
      .ypbpr_full          (ypbpr_full),
      .mute                (mute),
      .busy                (busy)
   );

   assign dut_mode = {scanlines, scandoubler_disable, hq2x, ypbpr, ypbpr_full};

   always #5 clk_sys = ~clk_sys;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- frame-level reference model ----------------
   // A pending change waits for a number of frame events (VSync rises seen two
   // clocks late, or TIMEOUT silent cycles): 1 for a fast change, else
   // MUTE_TB before a one-cycle apply step and SETTLE_TB after it.
   logic [5:0] m_mode, m_shadow;
   bit         m_pend, m_fast, m_applied, m_apply, m_ack;
   int         m_edges, m_silent, m_warm;
   logic [2:0] m_vs;
   logic [5:0] req_bits;

   assign req_bits = {cfg_if.cfg_scanlines, cfg_if.cfg_sd_disable, cfg_if.cfg_hq2x,
                      cfg_if.cfg_ypbpr, cfg_if.cfg_ypbpr_full};

   initial begin : model
      bit rise, ev;
      int need, n;
      m_mode = '0; m_shadow = '0; m_pend = 0; m_fast = 0; m_applied = 0; m_apply = 0;
      m_ack = 0; m_edges = 0; m_silent = 0; m_warm = 0; m_vs = '0;
      forever begin
         @(posedge clk_sys or negedge reset_n);
         if (!reset_n) begin
            m_mode = '0; m_shadow = '0; m_pend = 0; m_fast = 0; m_applied = 0; m_apply = 0;
            m_ack = 0; m_edges = 0; m_silent = 0; m_warm = 0; m_vs = '0;
         end else begin
            rise = m_vs[1] & ~m_vs[2];
            m_vs = {m_vs[1:0], vsync};
            if (m_warm < 2) begin
               m_warm++;
            end else if (!m_pend) begin
               if (cfg_if.cfg_req && !m_ack) begin
                  m_ack    = 1;
                  m_shadow = req_bits;
                  if (req_bits != m_mode) begin
                     m_pend    = 1;
                     m_fast    = ((req_bits ^ m_mode) & ~FAST_BITS) == 6'd0;
                     m_applied = 0;
                     m_apply   = 0;
                     m_edges   = 0;
                     m_silent  = 0;
                  end
               end else begin
                  m_ack = 0;
               end
            end else begin
               m_ack = 0;
               ev    = rise || (m_silent == TIMEOUT_TB);
               if (m_apply) begin
                  m_mode = m_shadow; m_apply = 0; m_applied = 1; m_edges = 0; m_silent = 0;
               end else begin
                  need = m_fast ? 1 : (m_applied ? SETTLE_TB : MUTE_TB);
                  n    = (m_edges < 255) ? m_edges + int'(ev) : 255;
                  if (n >= need) begin
                     if (m_fast || m_applied) begin
                        m_mode = m_shadow;
                        m_pend = 0;
                     end else begin
                        m_apply = 1;
                     end
                     m_edges  = 0;
                     m_silent = 0;
                  end else begin
                     m_edges  = n;
                     m_silent = ev ? 0 : m_silent + 1;
                  end
               end
            end
         end
      end
   end

   // Compare every cycle, away from the active edge.
   initial begin : compare
      forever begin
         @(negedge clk_sys);
         check("mode", 32'(dut_mode), 32'(m_mode));
         check("mute", 32'(mute), 32'(m_pend && !m_fast));
         check("busy", 32'(busy), 32'(m_pend));
         check("ack",  32'(cfg_if.cfg_ack), 32'(m_ack));
      end
   end

   // VSync source: 3-cycle pulse every vs_period cycles, optionally jittered.
   initial begin : vs_gen
      int vs_cnt;
      vs_cnt = 0;
      forever begin
         @(negedge clk_sys);
         if (vs_auto) begin
            vs_cnt++;
            if (vs_cnt >= vs_period) begin
               vs_cnt = 0;
               if (vs_rand)
                  vs_period = ($urandom_range(0, 9) == 0) ? 130 : int'($urandom_range(6, 40));
            end
            vsync = (vs_cnt < 3);
         end else begin
            vsync = 1'b0;
         end
      end
   end

   task automatic set_cfg(input logic [5:0] m);
      {cfg_if.cfg_scanlines, cfg_if.cfg_sd_disable, cfg_if.cfg_hq2x,
       cfg_if.cfg_ypbpr, cfg_if.cfg_ypbpr_full} = m;
   endtask

   // Raise a request at the current negedge; return at the negedge showing ack.
   task automatic send(input logic [5:0] m, output int lat);
      set_cfg(m);
      cfg_if.cfg_req = 1'b1;
      lat = 0;
      do begin
         @(negedge clk_sys);
         lat++;
      end while (cfg_if.cfg_ack !== 1'b1 && lat < 3000);
      check("ack_seen", 32'(cfg_if.cfg_ack), 1);
      cfg_if.cfg_req = 1'b0;
   endtask

   // From the current negedge (n=0), follow the switch until busy drops.
   task automatic watch(input logic [5:0] target, output int n_change, output int n_done,
                        output bit mute_seen, output bit mute_at_change);
      int n;
      n = 0; n_change = -1; mute_seen = 0; mute_at_change = 0;
      forever begin
         if (dut_mode == target && n_change < 0) begin
            n_change       = n;
            mute_at_change = mute;
         end
         if (mute) mute_seen = 1;
         if (!busy || n >= 4000) break;
         @(negedge clk_sys);
         n++;
      end
      n_done = n;
      check("busy_falls", 32'(busy), 0);
   endtask

   task automatic wait_mode(input logic [5:0] target);
      int n;
      n = 0;
      while (dut_mode !== target && n < 3000) begin
         @(negedge clk_sys);
         n++;
      end
      check("mode_reached", 32'(dut_mode), 32'(target));
   endtask

   initial begin : main
      int lat, nc, nd, n, n_idle, n_ack;
      bit ms, mc;
      cfg_if.cfg_req = 1'b0;
      set_cfg(6'd0);
      #1 reset_n = 1'b0;
      repeat (3) @(negedge clk_sys);
      check("reset_state", 32'({dut_mode, mute, busy, cfg_if.cfg_ack}), 0);
      reset_n = 1'b1;
      repeat (5) @(negedge clk_sys);

      // Lost sync: VSync held low, everything completes by timeouts.
      check("idle_before_lost_sync", 32'(busy), 0);
      send(6'b00_0010, lat);
      check("lost_ack_latency", lat, 1);
      check("lost_mute_on_entry", 32'(mute), 1);
      watch(6'b00_0010, nc, nd, ms, mc);
      check("lost_apply_cycle", nc, 102);
      check("lost_done_cycle", nd, 304);

      // Full switch with running VSync.
      vs_auto = 1'b1;
      repeat (30) @(negedge clk_sys);
      send(6'b00_1010, lat);
      check("full_ack_latency", lat, 1);
      watch(6'b00_1010, nc, nd, ms, mc);
      check("full_mute_at_apply", 32'(mc), 1);
      check("full_settle_two_frames", 32'(nd - nc >= 20), 1);
      check("full_mode_done", 32'(dut_mode), 32'(6'b00_1010));
      check("full_mute_released", 32'(mute), 0);

      // Fast path: scanlines only.
      send(6'b10_1010, lat);
      watch(6'b10_1010, nc, nd, ms, mc);
      check("fast_never_muted", 32'(ms), 0);
      check("fast_apply_with_idle", nc, nd);
      check("fast_mode_done", 32'(dut_mode), 32'(6'b10_1010));

      // No-op request.
      send(6'b10_1010, lat);
      watch(6'b10_1010, nc, nd, ms, mc);
      check("noop_never_busy", nd, 0);
      check("noop_mode_kept", 32'(dut_mode), 32'(6'b10_1010));

      // Request held while the previous switch settles.
      send(6'b10_1110, lat);
      wait_mode(6'b10_1110);
      check("held_in_settle", 32'(mute), 1);
      set_cfg(6'b01_1110);
      cfg_if.cfg_req = 1'b1;
      n = 0; n_idle = -1; n_ack = -1;
      while (n_ack < 0 && n < 3000) begin
         @(negedge clk_sys);
         n++;
         if (!busy && n_idle < 0) n_idle = n;
         if (cfg_if.cfg_ack) n_ack = n;
      end
      cfg_if.cfg_req = 1'b0;
      check("held_ack_first_idle", n_ack - n_idle, 1);
      watch(6'b01_1110, nc, nd, ms, mc);
      check("held_second_mode", 32'(dut_mode), 32'(6'b01_1110));

      // Reset while settling: outputs clear without a clock edge.
      send(6'b01_1010, lat);
      wait_mode(6'b01_1010);
      check("rst_in_settle", 32'(mute), 1);
      #2 reset_n = 1'b0;
      #1;
      check("async_reset_outputs", 32'({dut_mode, mute, busy, cfg_if.cfg_ack}), 0);
      repeat (2) @(negedge clk_sys);
      reset_n = 1'b1;
      send(6'b00_0001, lat);
      check("ack_after_reset_sync", lat, 3);
      watch(6'b00_0001, nc, nd, ms, mc);
      check("post_reset_fast_mode", 32'(dut_mode), 32'(6'b00_0001));

      // Randomized requests with jittered and occasionally lost VSync.
      vs_rand = 1'b1;
      for (int i = 0; i < 40; i++) begin
         logic [5:0] m;
         int         r;
         repeat ($urandom_range(0, 60)) @(negedge clk_sys);
         r = int'($urandom_range(0, 3));
         m = 6'($urandom);
         if (r == 0)      m = m_mode;
         else if (r == 1) m = (m_mode & ~FAST_BITS) | (m & FAST_BITS);
         send(m, lat);
      end
      n = 0;
      while (busy && n < 3000) begin
         @(negedge clk_sys);
         n++;
      end
      check("random_drain", 32'(busy), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
